wire_pair_monitor: RTL



---
 rtl/wire_pair_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wire_pair_monitor.sv
// wire_pair_monitor: counts synced rising edges on two wire-test lines and flags cycles where they disagree.
// Optional WIRE_MON_TIMEOUT_EN ends a run after 2^CNT_W-1 RUN cycles without a b edge.
module wire_pair_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             b_in,
    input  logic             c_in,
    input  logic [CNT_W-1:0] target_edges,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] b_edges,
    output logic [CNT_W-1:0] c_edges,
    output logic [CNT_W-1:0] err_count,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = 1;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d, c_sync_q, c_sync_d;
    logic                   b_prev_q, b_prev_d, c_prev_q, c_prev_d;
    logic                   b_s, c_s, b_rise, c_rise;
    logic [CNT_W-1:0]       target_q, target_d, b_edges_q, b_edges_d;
    logic [CNT_W-1:0]       c_edges_q, c_edges_d, err_q, err_d;
    logic                   mismatch_q, mismatch_d, busy_q, busy_d, done_q, done_d;
`ifdef WIRE_MON_TIMEOUT_EN
    logic [CNT_W-1:0]       idle_q, idle_d;
    logic                   timeout_q, timeout_d;
`endif

    assign b_s    = b_sync_q[SYNC_STAGES-1];
    assign c_s    = c_sync_q[SYNC_STAGES-1];
    assign b_rise = b_s & ~b_prev_q;
    assign c_rise = c_s & ~c_prev_q;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        b_edges_d  = b_edges_q;
        c_edges_d  = c_edges_q;
        err_d      = err_q;
        mismatch_d = mismatch_q;
        b_sync_d   = {b_sync_q[SYNC_STAGES-2:0], b_in};
        c_sync_d   = {c_sync_q[SYNC_STAGES-2:0], c_in};
        // prev tracks synced value every cycle, so arming never sees a stale edge
        b_prev_d   = b_s;
        c_prev_d   = c_s;
`ifdef WIRE_MON_TIMEOUT_EN
        idle_d     = idle_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d    = RUN;
                target_d   = target_edges;
                b_edges_d  = '0;
                c_edges_d  = '0;
                err_d      = '0;
                mismatch_d = 1'b0;
`ifdef WIRE_MON_TIMEOUT_EN
                idle_d     = '0;
                timeout_d  = 1'b0;
`endif
            end
            RUN: begin
                b_edges_d  = (b_rise && b_edges_q != MAX) ? b_edges_q + ONE : b_edges_q;
                c_edges_d  = (c_rise && c_edges_q != MAX) ? c_edges_q + ONE : c_edges_q;
                err_d      = (b_s != c_s && err_q != MAX) ? err_q + ONE : err_q;
                mismatch_d = mismatch_q | (b_s != c_s);
                state_d    = (target_q == '0 || b_edges_d == target_q) ? DONE : RUN;
`ifdef WIRE_MON_TIMEOUT_EN
                idle_d     = b_rise ? '0 : (idle_q == MAX ? idle_q : idle_q + ONE);
                if (idle_d == MAX) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            b_edges_q  <= '0;
            c_edges_q  <= '0;
            err_q      <= '0;
            mismatch_q <= 1'b0;
            b_sync_q   <= '0;
            c_sync_q   <= '0;
            b_prev_q   <= 1'b0;
            c_prev_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef WIRE_MON_TIMEOUT_EN
            idle_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            b_edges_q  <= b_edges_d;
            c_edges_q  <= c_edges_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            b_sync_q   <= b_sync_d;
            c_sync_q   <= c_sync_d;
            b_prev_q   <= b_prev_d;
            c_prev_q   <= c_prev_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef WIRE_MON_TIMEOUT_EN
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign b_edges   = b_edges_q;
    assign c_edges   = c_edges_q;
    assign err_count = err_q;
`ifdef WIRE_MON_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif
endmodule
